// File: rtl/block_plotter.sv
// block_plotter: rectangle rasteriser for the VGA pixel path.
// Accepts an origin, size, colour and mode on a start pulse, then walks the
// rectangle in raster order presenting one pixel per clock with a plot strobe.
// Supports fill/outline, erase-to-background and screen-edge clipping, and
// signals completion with a busy/done handshake.
module block_plotter #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int MAX_W    = 16,
  parameter int MAX_H    = 16,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = '0,
  localparam int WW = $clog2(MAX_W + 1),
  localparam int HW = $clog2(MAX_H + 1)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x,
  input  logic [Y_W-1:0]      y,
  input  logic [WW-1:0]       w,
  input  logic [HW-1:0]       h,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                outline,
  input  logic                erase,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_t;

  state_t          state;
  logic [X_W-1:0]  x0;
  logic [Y_W-1:0]  y0;
  logic [WW-1:0]   w_l;
  logic [HW-1:0]   h_l;
  logic            outline_l;
  logic [WW-1:0]   cx;
  logic [HW-1:0]   cy;

  // Requested sizes larger than the supported maximum are clamped, not wrapped.
  function automatic logic [WW-1:0] clamp_w(input logic [WW-1:0] v);
    return (v > WW'(MAX_W)) ? WW'(MAX_W) : v;
  endfunction

  function automatic logic [HW-1:0] clamp_h(input logic [HW-1:0] v);
    return (v > HW'(MAX_H)) ? HW'(MAX_H) : v;
  endfunction

  // Clip test uses the untruncated sums so a rectangle running past the
  // coordinate range never wraps back onto the visible screen.
  function automatic logic is_clipped(input logic [X_W-1:0] xb, input logic [WW-1:0] c,
                                      input logic [Y_W-1:0] yb, input logic [HW-1:0] r);
    logic [X_W:0] sx;
    logic [Y_W:0] sy;
    sx = {1'b0, xb} + (X_W+1)'(c);
    sy = {1'b0, yb} + (Y_W+1)'(r);
    return (sx >= (X_W+1)'(SCREEN_W)) || (sy >= (Y_W+1)'(SCREEN_H));
  endfunction

  // Interior pixels are suppressed in outline mode; with w<=2 or h<=2 there
  // is no interior, so every pixel is a border pixel.
  function automatic logic is_interior(input logic ol,
                                       input logic [WW-1:0] c, input logic [WW-1:0] wd,
                                       input logic [HW-1:0] r, input logic [HW-1:0] ht);
    return ol && (c != '0) && (c != wd - 1'b1) && (r != '0) && (r != ht - 1'b1);
  endfunction

  logic [WW-1:0] w_c;
  logic [HW-1:0] h_c;
  logic          last_col;
  logic          last_row;
  logic [WW-1:0] cx_nx;
  logic [HW-1:0] cy_nx;

  // Clamped request sizes and the raster position of the next pixel.
  always_comb begin
    w_c      = clamp_w(w);
    h_c      = clamp_h(h);
    last_col = (cx == w_l - 1'b1);
    last_row = (cy == h_l - 1'b1);
    cx_nx    = last_col ? '0 : cx + 1'b1;
    cy_nx    = last_col ? cy + 1'b1 : cy;
  end

  // Control FSM with registered pixel outputs: each edge loads the outputs
  // for the pixel presented in the following cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      x0         <= '0;
      y0         <= '0;
      w_l        <= '0;
      h_l        <= '0;
      outline_l  <= 1'b0;
      cx         <= '0;
      cy         <= '0;
      x_out      <= '0;
      y_out      <= '0;
      colour_out <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          plot <= 1'b0;
          if (start) begin
            x0         <= x;
            y0         <= y;
            w_l        <= w_c;
            h_l        <= h_c;
            outline_l  <= outline;
            colour_out <= erase ? BG_COLOUR : colour;
            cx         <= '0;
            cy         <= '0;
            busy       <= 1'b1;
            if ((w_c == '0) || (h_c == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= DRAW;
              x_out <= x;
              y_out <= y;
              // The first pixel is a corner, so only clipping can hide it.
              plot  <= !is_clipped(x, '0, y, '0);
            end
          end
        end
        DRAW: begin
          if (last_col && last_row) begin
            state <= DONE;
            cx    <= '0;
            cy    <= '0;
            plot  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cx    <= cx_nx;
            cy    <= cy_nx;
            x_out <= x0 + X_W'(cx_nx);
            y_out <= y0 + Y_W'(cy_nx);
            plot  <= !is_clipped(x0, cx_nx, y0, cy_nx) &&
                     !is_interior(outline_l, cx_nx, w_l, cy_nx, h_l);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
          plot  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_plotter.sv
// tb_block_plotter: randomized and directed stimulus for block_plotter,
// checked cycle by cycle against a raster-walk reference model.
module tb_block_plotter;
  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int COLOUR_W = 3;
  localparam int MAX_W = 16;
  localparam int MAX_H = 16;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int BG = 0;
  localparam int WW = $clog2(MAX_W + 1);
  localparam int HW = $clog2(MAX_H + 1);

  logic clk = 1'b0;
  logic reset, start, outline, erase;
  logic [X_W-1:0] x, x_out;
  logic [Y_W-1:0] y, y_out;
  logic [WW-1:0] w;
  logic [HW-1:0] h;
  logic [COLOUR_W-1:0] colour, colour_out;
  logic plot, busy, done;

  int n_checks = 0;
  int n_fail = 0;

  block_plotter #(
    .X_W(X_W), .Y_W(Y_W), .COLOUR_W(COLOUR_W), .MAX_W(MAX_W), .MAX_H(MAX_H),
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .BG_COLOUR(COLOUR_W'(BG))
  ) dut (
    .clk(clk), .reset(reset), .start(start), .x(x), .y(y), .w(w), .h(h),
    .colour(colour), .outline(outline), .erase(erase),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out),
    .plot(plot), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Issue one rectangle and check every cycle until the post-done idle cycle.
  // noise: toggle start and scramble operand inputs while the draw runs.
  task automatic run_rect(input int xi, input int yi, input int wi, input int hi,
                          input int col, input bit ol, input bit er, input bit noise,
                          output int nplot);
    int cw, ch, px, py, ecol;
    bit eplot, interior;
    cw = (wi > MAX_W) ? MAX_W : wi;
    ch = (hi > MAX_H) ? MAX_H : hi;
    ecol = er ? BG : col;
    nplot = 0;
    @(negedge clk);
    x = X_W'(xi); y = Y_W'(yi); w = WW'(wi); h = HW'(hi);
    colour = COLOUR_W'(col); outline = ol; erase = er; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int r = 0; r < ch; r++) begin
      for (int c = 0; c < cw; c++) begin
        if (noise) begin
          start = 1'($urandom_range(0, 1));
          x = X_W'($urandom); y = Y_W'($urandom); w = WW'($urandom);
          colour = COLOUR_W'($urandom); erase = 1'($urandom);
        end
        px = xi + c;
        py = yi + r;
        interior = ol && c > 0 && c < cw - 1 && r > 0 && r < ch - 1;
        eplot = (px < SCREEN_W) && (py < SCREEN_H) && !interior;
        chk("plot", 32'(plot), 32'(eplot));
        chk("x_out", 32'(x_out), 32'(px % (1 << X_W)));
        chk("y_out", 32'(y_out), 32'(py % (1 << Y_W)));
        chk("colour_out", 32'(colour_out), 32'(ecol));
        chk("busy_draw", 32'(busy), 32'd1);
        chk("done_draw", 32'(done), 32'd0);
        if (plot === 1'b1) nplot++;
        @(negedge clk);
      end
    end
    if (noise) start = 1'b1;
    chk("done_pulse", 32'(done), 32'd1);
    chk("busy_done", 32'(busy), 32'd1);
    chk("plot_done", 32'(plot), 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after", 32'(busy), 32'd0);
    chk("done_after", 32'(done), 32'd0);
    chk("plot_after", 32'(plot), 32'd0);
  endtask

  initial begin
    int np;
    reset = 1'b1; start = 1'b0; x = '0; y = '0; w = '0; h = '0;
    colour = '0; outline = 1'b0; erase = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_x", 32'(x_out), 0);
    chk("rst_y", 32'(y_out), 0);
    chk("rst_col", 32'(colour_out), 0);
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    run_rect(10, 20, 4, 4, 5, 0, 0, 0, np);   chk("fill_count", np, 16);
    run_rect(0, 0, 5, 3, 2, 1, 0, 0, np);     chk("outline_count", np, 12);
    run_rect(158, 118, 4, 4, 6, 0, 0, 0, np); chk("clip_count", np, 4);
    run_rect(5, 5, 0, 5, 1, 0, 0, 0, np);     chk("zero_count", np, 0);
    run_rect(0, 0, 20, 1, 4, 0, 0, 0, np);    chk("clamp_count", np, 16);
    run_rect(30, 40, 2, 2, 7, 0, 1, 1, np);   chk("erase_count", np, 4);
    run_rect(3, 3, 1, 1, 3, 1, 0, 0, np);     chk("one_count", np, 1);
    run_rect(7, 9, 2, 6, 3, 1, 0, 0, np);     chk("thin_outline", np, 12);

    // Reset on the 6th DRAW cycle of an 8x8 rectangle.
    @(negedge clk);
    x = 8'd50; y = 7'd60; w = 5'd8; h = 5'd8; colour = 3'd6;
    outline = 1'b0; erase = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("pre_rst_x", 32'(x_out), 32'(50 + k));
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    chk("arst_x", 32'(x_out), 0);
    chk("arst_y", 32'(y_out), 0);
    chk("arst_col", 32'(colour_out), 0);
    chk("arst_plot", 32'(plot), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_done", 32'(done), 0);
      chk("post_rst_busy", 32'(busy), 0);
    end
    run_rect(50, 60, 8, 8, 6, 0, 0, 0, np);   chk("after_rst_count", np, 64);

    for (int i = 0; i < 40; i++) begin
      run_rect(int'($urandom_range(0, 255)), int'($urandom_range(0, 127)),
               int'($urandom_range(0, 20)), int'($urandom_range(0, 20)),
               int'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
               1'($urandom), np);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/block_plotter.md
# block_plotter

Parametrised rectangle plotter for the VGA pixel path. On a `start` pulse it latches an origin, a size, a colour and a mode, then emits one pixel per clock in raster order, row-major from the top-left. Each pixel has a `plot` write strobe for the VGA adapter. The block adds variable rectangle size, outline-only drawing, erase-to-background and screen-edge clipping, and reports completion with a `busy`/`done` handshake to the game control FSM.

## Interface
Parameters:
- `X_W`, default 8: x coordinate width.
- `Y_W`, default 7: y coordinate width.
- `COLOUR_W`, default 3: colour width.
- `MAX_W`, default 16: maximum rectangle width in pixels.
- `MAX_H`, default 16: maximum rectangle height in pixels.
- `SCREEN_W`, default 160: visible columns. Any x >= `SCREEN_W` is off-screen.
- `SCREEN_H`, default 120: visible rows. Any y >= `SCREEN_H` is off-screen.
- `BG_COLOUR`, default 3'b000: colour driven in erase mode.

Ports (`WW` = $clog2(`MAX_W`+1), `HW` = $clog2(`MAX_H`+1)):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high. Forces the IDLE state and the reset values below.
- `start`  in  1  request. Sampled only in IDLE.
- `x`  in  `X_W`  origin column.
- `y`  in  `Y_W`  origin row.
- `w`  in  `WW`  rectangle width.
- `h`  in  `HW`  rectangle height.
- `colour`  in  `COLOUR_W`  fill colour.
- `outline`  in  1  when 1, plot only the border pixels.
- `erase`  in  1  when 1, drive `BG_COLOUR` instead of `colour`.
- `x_out`  out  `X_W`  current pixel column.
- `y_out`  out  `Y_W`  current pixel row.
- `colour_out`  out  `COLOUR_W`  current pixel colour.
- `plot`  out  1  pixel write strobe.
- `busy`  out  1  high from the cycle after acceptance through the DONE cycle.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, DRAW, DONE.
- IDLE, `start`=1:
  - Latch `x`, `y`, `colour`, `outline`, `erase`.
  - Latch `w` and `h`, each clamped to `MAX_W`/`MAX_H` when larger.
  - Clear the column counter `cx` and the row counter `cy`.
  - If the clamped w or h is 0, go to DONE. Otherwise go to DRAW.
- IDLE, `start`=0: stay in IDLE.
- DRAW, each cycle:
  - `x_out` = x0+`cx`, truncated to `X_W`. `y_out` = y0+`cy`, truncated to `Y_W`.
  - `cx` increments. When `cx` = w-1, `cx` returns to 0 and `cy` increments.
  - When `cx` = w-1 and `cy` = h-1, go to DONE.
- `plot` = 1 in DRAW unless either condition holds:
  - Clipped: the untruncated sum x0+`cx` (`X_W`+1 bits) is >= `SCREEN_W`, or y0+`cy` (`Y_W`+1 bits) is >= `SCREEN_H`.
  - Outline interior: `outline`=1 and 0 < `cx` < w-1 and 0 < `cy` < h-1.
- Clipped and interior pixels still consume their cycle; no pixel is ever skipped in time.
- `colour_out` = `BG_COLOUR` when the latched erase bit is 1, else the latched colour. Held outside DRAW.
- DONE: `done`=1 for exactly one cycle, then go to IDLE. A `start` asserted in DONE is ignored.
- `start` asserted in DRAW or DONE is ignored. Latched operands do not change until the next acceptance.
- Reset mid-DRAW: go to IDLE immediately. No `done` pulse. Remaining pixels are abandoned.

## Timing
- Reset values: state IDLE, `cx`=`cy`=0, `x_out`=0, `y_out`=0, `colour_out`=0, `plot`=0, `busy`=0, `done`=0.
- Start accepted at edge T:
  - Pixel k (0-based) is presented in cycle T+1+k, for k = 0..w*h-1.
  - `done` is high in cycle T+1+w*h.
  - `busy` is high in cycles T+1 through T+1+w*h inclusive.
  - The next start is accepted at the edge ending cycle T+2+w*h, at the earliest.
- Zero-size request: `done` is high in cycle T+1, with no `plot` in between.
- `plot`, `x_out` and `y_out` are decoded from registered state only. There is no combinational path from any input to any output.
- 1x1 rectangle: `cx` = w-1 = 0 on the first DRAW cycle, so DRAW lasts exactly one cycle.
- Outline with w<=2 or h<=2: every pixel is a border pixel, so all are plotted.

## Test plan
- Fill 4x4 at (10,20), colour 3'b101 -> 16 consecutive `plot` cycles. Pixels (10,20),(11,20)…(13,23) in raster order, colour 101. `done` 17 cycles after start. `busy` high for 17 cycles.
- Outline 5x3 at (0,0) -> 15 DRAW cycles. `plot`=0 only at (1,1),(2,1),(3,1). `done` in cycle T+16.
- Clip 4x4 at (158,118) -> 16 DRAW cycles. `plot`=1 only at (158..159, 118..119), 4 pixels total.
- w=0, h=5 -> no `plot`. `done` in cycle T+1. w=20 with `MAX_W`=16 -> 16 columns drawn.
- Erase 2x2 at (30,40), colour 3'b111 -> `colour_out`=`BG_COLOUR` on all 4 plots. A second `start` pulsed during DRAW is ignored, giving exactly one `done`.
- Reset asserted on the 6th DRAW cycle of an 8x8 -> outputs reach their reset values asynchronously. No `done`. A subsequent start draws correctly from (x0,y0).
